// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - parametrised UART receive core with majority-vote sampling
//
// Purpose:
//   Receives asynchronous serial frames (start, DATA_BITS data LSB first,
//   optional parity, STOP_BITS stop bits) on a clock running at
//   OVERSAMPLE x baud. Each bit is decided by a majority vote of three
//   samples around mid-bit. A completed frame is presented as a one-cycle
//   o_rx_valid pulse together with parity and framing status.
//
// Ports:
//   clk          - OVERSAMPLE x baud clock
//   reset        - synchronous, active-low
//   i_rx_data    - asynchronous serial line, idle high
//   o_rx_data    - last received word, held until the next o_rx_valid
//   o_rx_valid   - one-cycle frame-complete pulse
//   o_parity_err - parity status of the delivered frame (0 without parity)
//   o_frame_err  - set when any stop bit of the delivered frame voted 0
//   o_busy       - receiver is inside a frame or waiting out a break

module uart_rx_core #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_rx_data,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int H  = OVERSAMPLE / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(H);
  localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == 1);
  localparam logic          HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic                   sync_1;
  logic                   rx_s;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_cnt;
  logic [1:0]             samp;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_err;
  logic                   frm_err;

  logic                   at_last;
  logic                   at_dec;
  logic                   vote;
  logic                   deliver;
  logic                   cnt_hold;

  // The third vote sample is the live rx_s on the decision edge itself.
  assign at_last = (cnt == CNT_LAST);
  assign at_dec  = (cnt == CNT_DEC);
  assign vote    = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign deliver = (state == ST_STOP) && (bit_cnt == STOP_LAST) && at_dec;

  // The FSM is already back in IDLE during the delivery cycle, so the
  // valid pulse keeps busy asserted through it.
  assign o_busy = (state != ST_IDLE) | o_rx_valid;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (!rx_s) next_state = ST_START;
      ST_START: begin
        if (at_dec && vote)  next_state = ST_IDLE;
        else if (at_last)    next_state = ST_DATA;
      end
      ST_DATA: begin
        if (at_last && (bit_cnt == DATA_LAST))
          next_state = HAS_PAR ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (at_last) next_state = ST_STOP;
      // The last stop bit is not waited out so the next start edge can be
      // caught immediately after delivery.
      ST_STOP:   if (deliver) next_state = vote ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rx_s) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  assign cnt_hold = (state == ST_IDLE) || (state == ST_BREAK) ||
                    (next_state == ST_IDLE) || (next_state == ST_BREAK);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_1       <= 1'b1;
      rx_s         <= 1'b1;
      state        <= ST_IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      samp         <= '0;
      shift        <= '0;
      par_err      <= 1'b0;
      frm_err      <= 1'b0;
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      sync_1     <= i_rx_data;
      rx_s       <= sync_1;
      state      <= next_state;
      o_rx_valid <= 1'b0;

      if (cnt_hold || at_last) cnt <= '0;
      else                     cnt <= cnt + CW'(1);

      if (cnt == CNT_S0) samp[0] <= rx_s;
      if (cnt == CNT_S1) samp[1] <= rx_s;

      if (state != next_state)
        bit_cnt <= '0;
      else if (at_last && ((state == ST_DATA) || (state == ST_STOP)))
        bit_cnt <= bit_cnt + 4'd1;

      if ((state == ST_IDLE) && (next_state == ST_START)) begin
        par_err <= 1'b0;
        frm_err <= 1'b0;
      end

      if ((state == ST_DATA) && at_dec)
        shift <= {vote, shift[DATA_BITS-1:1]};

      if ((state == ST_PARITY) && at_dec)
        par_err <= (^shift) ^ vote ^ ODD_PAR;

      if ((state == ST_STOP) && at_dec && !vote)
        frm_err <= 1'b1;

      if (deliver) begin
        o_rx_data    <= shift;
        o_parity_err <= HAS_PAR & par_err;
        o_frame_err  <= frm_err | ~vote;
        o_rx_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core

module tb_uart_rx_core;

  localparam int OV_A = 8;
  localparam int DB_A = 8;
  localparam int OV_B = 4;
  localparam int DB_B = 7;
  localparam int PAR_B = 2;
  localparam int SB_B = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  logic [DB_A-1:0] a_data;
  logic            a_valid, a_perr, a_ferr, a_busy;
  logic [DB_B-1:0] b_data;
  logic            b_valid, b_perr, b_ferr, b_busy;

  uart_rx_core #(.OVERSAMPLE(OV_A), .DATA_BITS(DB_A), .PARITY(0), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .i_rx_data(rx_a),
    .o_rx_data(a_data), .o_rx_valid(a_valid), .o_parity_err(a_perr),
    .o_frame_err(a_ferr), .o_busy(a_busy)
  );

  uart_rx_core #(.OVERSAMPLE(OV_B), .DATA_BITS(DB_B), .PARITY(PAR_B), .STOP_BITS(SB_B)) dut_p (
    .clk(clk), .reset(reset), .i_rx_data(rx_b),
    .o_rx_data(b_data), .o_rx_valid(b_valid), .o_parity_err(b_perr),
    .o_frame_err(b_ferr), .o_busy(b_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  int  errors = 0;
  int  checks = 0;

  always @(negedge clk) begin
    ev_t e;
    if (a_valid) begin
      e.cyc = cyc; e.data = 9'(a_data); e.perr = a_perr; e.ferr = a_ferr;
      qa.push_back(e);
    end
    if (b_valid) begin
      e.cyc = cyc; e.data = 9'(b_data); e.perr = b_perr; e.ferr = b_ferr;
      qb.push_back(e);
    end
  end

  // Drives one frame; exp is the frame the receiver should report, derived
  // from the framing rules. rst_at >= 0 aborts the frame with a reset pulse.
  task automatic send(input int sel, input logic [8:0] data, input logic pbit,
                      input logic [1:0] stops, input int glitch_bit,
                      input int rst_at, output ev_t exp);
    int ov, db, par, sb, n, t;
    logic [15:0] bits;
    logic [8:0] d;
    logic v;
    if (sel == 0) begin ov = OV_A; db = DB_A; par = 0; sb = 1; end
    else begin ov = OV_B; db = DB_B; par = PAR_B; sb = SB_B; end
    d = data & 9'((1 << db) - 1);
    bits = '0;
    n = 1;
    for (int i = 0; i < db; i++) begin bits[n] = d[i]; n++; end
    if (par != 0) begin bits[n] = pbit; n++; end
    for (int s = 0; s < sb; s++) begin bits[n] = stops[s]; n++; end
    @(negedge clk);
    exp.cyc  = cyc + 1 + (n - 1) * ov + ov / 2 + 4;
    exp.data = d;
    exp.perr = (par != 0) && ((($countones(d) + int'(pbit)) % 2) != ((par == 1) ? 1 : 0));
    exp.ferr = (sb == 1) ? !stops[0] : !(stops[0] && stops[1]);
    t = 0;
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < ov; i++) begin
        v = bits[b] ^ logic'((b == glitch_bit) && (i == ov / 2 + 1));
        if (sel == 0) rx_a = v; else rx_b = v;
        if (t == rst_at) reset = 1'b0;
        @(negedge clk);
        if (t == rst_at) begin
          reset = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
          return;
        end
        t++;
      end
    end
  endtask

  task automatic get_ev(input int sel, output ev_t ev, output bit got);
    got = 1'b0;
    ev = '{default: 0};
    for (int i = 0; i < 300; i++) begin
      if (sel == 0 && qa.size() > 0) begin ev = qa.pop_front(); got = 1'b1; return; end
      if (sel == 1 && qb.size() > 0) begin ev = qb.pop_front(); got = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (a_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", a_data); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", a_valid); end
    checks++; if (a_perr !== 1'b0 || a_ferr !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", a_perr, a_ferr); end
    checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b expected 00", a_busy, b_busy); end
    reset = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (a_busy !== 1'b0 || qa.size() != 0) begin errors++; $display("FAIL idle_after_reset: busy %b events %0d expected 0 0", a_busy, qa.size()); end
  endtask

  task automatic test_basic();
    ev_t exp, ev;
    bit got;
    send(0, 9'h0A5, 1'b0, 2'b11, -1, -1, exp);
    get_ev(0, ev, got);
    checks++;
    if (!got) begin errors++; $display("FAIL basic_valid: got no pulse expected frame %0h", exp.data); end
    else begin
      checks++; if (ev.cyc != exp.cyc) begin errors++; $display("FAIL basic_latency: got edge %0d expected %0d", ev.cyc, exp.cyc); end
      checks++; if (ev.data !== 9'h0A5) begin errors++; $display("FAIL basic_data: got %0h expected a5", ev.data); end
      checks++; if (ev.perr !== 1'b0 || ev.ferr !== 1'b0) begin errors++; $display("FAIL basic_flags: got %b%b expected 00", ev.perr, ev.ferr); end
      while (cyc < ev.cyc + 1) @(negedge clk);
      checks++; if (a_busy !== 1'b0 || a_valid !== 1'b0) begin errors++; $display("FAIL basic_after: busy %b valid %b expected 0 0", a_busy, a_valid); end
    end
  endtask

  task automatic test_parity();
    ev_t exp, ev;
    bit got;
    for (int k = 0; k < 2; k++) begin
      send(1, 9'h041, (k == 0) ? 1'b1 : 1'b0, 2'b11, -1, -1, exp);
      get_ev(1, ev, got);
      checks++;
      if (!got) begin errors++; $display("FAIL parity_valid[%0d]: got no pulse expected frame", k); end
      else begin
        checks++; if (ev.data !== 9'h041 || ev.cyc != exp.cyc) begin errors++; $display("FAIL parity_data[%0d]: got %0h@%0d expected 41@%0d", k, ev.data, ev.cyc, exp.cyc); end
        checks++; if (ev.perr !== ((k == 0) ? 1'b1 : 1'b0) || ev.ferr !== 1'b0) begin errors++; $display("FAIL parity_err[%0d]: got %b%b expected %b0", k, ev.perr, ev.ferr, (k == 0)); end
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_glitch_reject();
    int busy_cycles = 0;
    @(negedge clk);
    rx_a = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 3) rx_a = 1'b1;
      @(negedge clk);
      if (a_busy) busy_cycles++;
    end
    checks++; if (busy_cycles != OV_A / 2 + 2) begin errors++; $display("FAIL reject_busy: got %0d cycles expected %0d", busy_cycles, OV_A / 2 + 2); end
    checks++; if (qa.size() != 0 || a_busy !== 1'b0) begin errors++; $display("FAIL reject_no_frame: events %0d busy %b expected 0 0", qa.size(), a_busy); end
  endtask

  task automatic test_break();
    ev_t exp, ev;
    bit got;
    send(0, 9'h03C, 1'b0, 2'b00, -1, -1, exp);
    repeat (40) @(negedge clk);
    checks++; if (qa.size() != 1) begin errors++; $display("FAIL break_count: got %0d events expected 1", qa.size()); end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL break_busy: got %b expected 1", a_busy); end
    if (qa.size() > 0) begin
      ev = qa.pop_front();
      checks++; if (ev.data !== 9'h03C || ev.ferr !== 1'b1 || ev.perr !== 1'b0 || ev.cyc != exp.cyc) begin
        errors++; $display("FAIL break_frame: got %0h f%b p%b @%0d expected 3c f1 p0 @%0d", ev.data, ev.ferr, ev.perr, ev.cyc, exp.cyc);
      end
    end
    qa.delete();
    rx_a = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (a_busy !== 1'b0 || qa.size() != 0) begin errors++; $display("FAIL break_exit: busy %b events %0d expected 0 0", a_busy, qa.size()); end
    send(0, 9'h05A, 1'b0, 2'b11, -1, -1, exp);
    get_ev(0, ev, got);
    checks++; if (!got || ev.data !== 9'h05A || ev.ferr !== 1'b0 || ev.cyc != exp.cyc) begin
      errors++; $display("FAIL break_next: got %0h f%b @%0d (seen %b) expected 5a f0 @%0d", ev.data, ev.ferr, ev.cyc, got, exp.cyc);
    end
  endtask

  task automatic test_back_to_back();
    ev_t e0, e1, e2, ev;
    bit got;
    send(0, 9'h096, 1'b0, 2'b11, 3, -1, e0);
    get_ev(0, ev, got);
    checks++; if (!got || ev.data !== 9'h096 || ev.cyc != e0.cyc) begin
      errors++; $display("FAIL sample_glitch: got %0h @%0d (seen %b) expected 96 @%0d", ev.data, ev.cyc, got, e0.cyc);
    end
    send(0, 9'h000, 1'b0, 2'b11, -1, -1, e1);
    send(0, 9'h0FF, 1'b0, 2'b11, -1, -1, e2);
    get_ev(0, ev, got);
    checks++; if (!got || ev.data !== 9'h000 || ev.cyc != e1.cyc || ev.ferr !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got %0h @%0d (seen %b) expected 0 @%0d", ev.data, ev.cyc, got, e1.cyc);
    end
    get_ev(0, ev, got);
    checks++; if (!got || ev.data !== 9'h0FF || ev.cyc != e2.cyc || ev.ferr !== 1'b0) begin
      errors++; $display("FAIL b2b_second: got %0h @%0d (seen %b) expected ff @%0d", ev.data, ev.cyc, got, e2.cyc);
    end
  endtask

  task automatic test_reset_mid();
    ev_t exp, ev;
    bit got;
    send(0, 9'h081, 1'b0, 2'b11, -1, 5 * OV_A, exp);
    checks++; if (a_data !== 8'h00 || a_valid !== 1'b0 || a_busy !== 1'b0 || a_perr !== 1'b0 || a_ferr !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: data %0h v%b b%b p%b f%b expected all 0", a_data, a_valid, a_busy, a_perr, a_ferr);
    end
    checks++; if (b_data !== 7'h00) begin errors++; $display("FAIL midreset_other: got %0h expected 0", b_data); end
    repeat (100) @(negedge clk);
    checks++; if (qa.size() != 0) begin errors++; $display("FAIL midreset_partial: got %0d events expected 0", qa.size()); end
    send(0, 9'h081, 1'b0, 2'b11, -1, -1, exp);
    get_ev(0, ev, got);
    checks++; if (!got || ev.data !== 9'h081 || ev.cyc != exp.cyc) begin
      errors++; $display("FAIL midreset_next: got %0h @%0d (seen %b) expected 81 @%0d", ev.data, ev.cyc, got, exp.cyc);
    end
  endtask

  task automatic test_random();
    ev_t exp, ev;
    bit got;
    for (int k = 0; k < 12; k++) begin
      send(0, 9'($urandom_range(0, 255)), 1'b0, 2'b11, -1, -1, exp);
      get_ev(0, ev, got);
      checks++; if (!got || ev.data !== exp.data || ev.cyc != exp.cyc || ev.perr !== exp.perr || ev.ferr !== exp.ferr) begin
        errors++; $display("FAIL rand_a[%0d]: got %0h p%b f%b @%0d expected %0h p%b f%b @%0d", k, ev.data, ev.perr, ev.ferr, ev.cyc, exp.data, exp.perr, exp.ferr, exp.cyc);
      end
    end
    for (int k = 0; k < 12; k++) begin
      send(1, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), {1'b1, 1'($urandom_range(0, 1))}, -1, -1, exp);
      get_ev(1, ev, got);
      checks++; if (!got || ev.data !== exp.data || ev.cyc != exp.cyc || ev.perr !== exp.perr || ev.ferr !== exp.ferr) begin
        errors++; $display("FAIL rand_b[%0d]: got %0h p%b f%b @%0d expected %0h p%b f%b @%0d", k, ev.data, ev.perr, ev.ferr, ev.cyc, exp.data, exp.perr, exp.ferr, exp.cyc);
      end
      repeat ($urandom_range(2, 6)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch_reject();
    test_break();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (20) @(negedge clk);
    checks++; if (qa.size() != 0 || qb.size() != 0) begin errors++; $display("FAIL stray_frames: got %0d/%0d expected 0/0", qa.size(), qb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
